// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 16-bit pipelined core.
//
// Takes the execute stage's outputs and runs LOAD/STORE transactions on the data
// memory over a req/ack handshake. It registers the instruction and the result
// for write-back. While a transaction is outstanding, stall holds the upstream stages.
//
// Ports:
//   clock, reset       clock (rising edge), asynchronous active-low reset
//   state              CPU run state; the stage advances only in `EXEC
//   mem_ir, reg_C      instruction and ALU result (reg_C is the memory address)
//   dw, smdr1          store request and store data
//   d_ack, d_rdata     memory acknowledge pulse and read data
//   d_req, d_we        registered memory request and write enable
//   d_addr, d_wdata    registered address and write data
//   wb_ir, reg_C1      instruction and result to write-back
//   stall              combinational upstream hold
//   mem_err            sticky timeout flag
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT
// ACCESS cycles without d_ack. When it is undefined, the stage waits indefinitely
// and mem_err is tied low.

`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b10000
`endif

module mem_access #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] mem_ir,
  input  logic [15:0] reg_C,
  input  logic        dw,
  input  logic [15:0] smdr1,
  input  logic        d_ack,
  input  logic [15:0] d_rdata,
  output logic        d_req,
  output logic        d_we,
  output logic [15:0] d_addr,
  output logic [15:0] d_wdata,
  output logic [15:0] wb_ir,
  output logic [15:0] reg_C1,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic {StIdle, StAccess} st_e;

  st_e         st_q, st_d;
  logic        d_req_q, d_req_d;
  logic        d_we_q, d_we_d;
  logic [15:0] d_addr_q, d_addr_d;
  logic [15:0] d_wdata_q, d_wdata_d;
  logic [15:0] wb_ir_q, wb_ir_d;
  logic [15:0] reg_c1_q, reg_c1_d;

  logic in_exec;
  logic is_load;
  logic is_mem_op;
  logic issue;
  logic timeout_hit;

  assign in_exec   = (state == `EXEC);
  assign is_load   = (mem_ir[15:11] == `LOAD);
  assign is_mem_op = is_load | dw;
  assign issue     = (st_q == StIdle) && in_exec && is_mem_op;

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  // cnt_q counts the ACCESS cycles already spent without an ack. The timeout
  // fires in the TIMEOUT-th ACCESS cycle. If d_ack arrives in that cycle, the ack wins.
  assign timeout_hit = (st_q == StAccess) && !d_ack && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q | timeout_hit;
    if (issue) begin
      cnt_d = 4'd0;
    end else if ((st_q == StAccess) && !d_ack) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_comb begin
    st_d      = st_q;
    d_req_d   = d_req_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    wb_ir_d   = wb_ir_q;
    reg_c1_d  = reg_c1_q;
    unique case (st_q)
      StIdle: begin
        if (in_exec) begin
          if (is_mem_op) begin
            d_req_d   = 1'b1;
            d_we_d    = dw;
            d_addr_d  = reg_C;
            d_wdata_d = dw ? smdr1 : 16'h0000;
            st_d      = StAccess;
          end else begin
            wb_ir_d  = mem_ir;
            reg_c1_d = reg_C;
          end
        end
      end
      StAccess: begin
        // Upstream holds mem_ir/reg_C/dw while stalled, so the issue-time
        // values are still present at completion.
        if (d_ack) begin
          d_req_d  = 1'b0;
          d_we_d   = 1'b0;
          wb_ir_d  = mem_ir;
          reg_c1_d = dw ? reg_C : d_rdata;
          st_d     = StIdle;
        end else if (timeout_hit) begin
          d_req_d  = 1'b0;
          d_we_d   = 1'b0;
          wb_ir_d  = 16'h0000;
          reg_c1_d = 16'h0000;
          st_d     = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q      <= StIdle;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= 16'h0000;
      d_wdata_q <= 16'h0000;
      wb_ir_q   <= 16'h0000;
      reg_c1_q  <= 16'h0000;
    end else begin
      st_q      <= st_d;
      d_req_q   <= d_req_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      wb_ir_q   <= wb_ir_d;
      reg_c1_q  <= reg_c1_d;
    end
  end

  assign stall = issue || ((st_q == StAccess) && !d_ack && !timeout_hit);

  assign d_req   = d_req_q;
  assign d_we    = d_we_q;
  assign d_addr  = d_addr_q;
  assign d_wdata = d_wdata_q;
  assign wb_ir   = wb_ir_q;
  assign reg_C1  = reg_c1_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access. The bench pushes the expected write-back
// {wb_ir, reg_C1} into a queue when it drives an instruction. It pops and
// compares that entry after the edge where the stage completes.

`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b10000
`endif

module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        state;
  logic [15:0] mem_ir;
  logic [15:0] reg_C;
  logic        dw;
  logic [15:0] smdr1;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] wb_ir;
  logic [15:0] reg_c1;
  logic        stall;
  logic        mem_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] sb_q[$];

  localparam logic [15:0] AddIr   = {5'b00001, 11'h123};
  localparam logic [15:0] LoadIr  = {`LOAD, 11'h045};
  localparam logic [15:0] StoreIr = {5'b00011, 11'h0AB};
  localparam logic        NotExec = ~`EXEC;

  mem_access #(.TIMEOUT(15)) dut (
    .clock   (clock),
    .reset   (reset),
    .state   (state),
    .mem_ir  (mem_ir),
    .reg_C   (reg_C),
    .dw      (dw),
    .smdr1   (smdr1),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .wb_ir   (wb_ir),
    .reg_C1  (reg_c1),
    .stall   (stall),
    .mem_err (mem_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wb(input string tag);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_wb_ir"}, {16'h0, wb_ir}, {16'h0, exp[31:16]});
      check({tag, "_reg_c1"}, {16'h0, reg_c1}, {16'h0, exp[15:0]});
    end
  endtask

  task automatic do_nonmem(input string tag, input logic [15:0] ir, input logic [15:0] c);
    state  = `EXEC;
    mem_ir = ir;
    reg_C  = c;
    dw     = 1'b0;
    smdr1  = 16'($urandom);
    sb_q.push_back({ir, c});
    #1 check({tag, "_stall"}, {31'h0, stall}, 32'd0);
    tick();
    check({tag, "_d_req"}, {31'h0, d_req}, 32'd0);
    check_wb(tag);
  endtask

  // ack_delay: ACCESS cycles without ack before the ack cycle.
  task automatic do_mem(input string tag, input logic [15:0] ir, input logic [15:0] addr,
                        input logic we, input logic [15:0] wdata, input logic [15:0] rdata,
                        input int ack_delay, input logic drop_state);
    logic [15:0] exp_wdata;
    exp_wdata = we ? wdata : 16'h0000;
    state  = `EXEC;
    mem_ir = ir;
    reg_C  = addr;
    dw     = we;
    smdr1  = wdata;
    sb_q.push_back({ir, we ? addr : rdata});
    #1;
    check({tag, "_issue_stall"}, {31'h0, stall}, 32'd1);
    check({tag, "_issue_req"}, {31'h0, d_req}, 32'd0);
    tick();
    for (int i = 0; i < ack_delay; i++) begin
      if (drop_state) state = NotExec;
      check({tag, "_req"}, {31'h0, d_req}, 32'd1);
      check({tag, "_we"}, {31'h0, d_we}, {31'h0, we});
      check({tag, "_addr"}, {16'h0, d_addr}, {16'h0, addr});
      check({tag, "_wdata"}, {16'h0, d_wdata}, {16'h0, exp_wdata});
      #1 check({tag, "_wait_stall"}, {31'h0, stall}, 32'd1);
      tick();
    end
    if (drop_state) state = NotExec;
    check({tag, "_ack_req"}, {31'h0, d_req}, 32'd1);
    check({tag, "_ack_addr"}, {16'h0, d_addr}, {16'h0, addr});
    check({tag, "_ack_wdata"}, {16'h0, d_wdata}, {16'h0, exp_wdata});
    d_ack   = 1'b1;
    d_rdata = rdata;
    #1 check({tag, "_ack_stall"}, {31'h0, stall}, 32'd0);
    tick();
    d_ack   = 1'b0;
    d_rdata = 16'($urandom);
    check({tag, "_done_req"}, {31'h0, d_req}, 32'd0);
    check({tag, "_done_we"}, {31'h0, d_we}, 32'd0);
    check_wb(tag);
  endtask

  initial begin
    reset   = 1'b0;
    state   = NotExec;
    mem_ir  = 16'h0;
    reg_C   = 16'h0;
    dw      = 1'b0;
    smdr1   = 16'h0;
    d_ack   = 1'b0;
    d_rdata = 16'h0;
    #12;
    check("rst_d_req", {31'h0, d_req}, 32'd0);
    check("rst_d_we", {31'h0, d_we}, 32'd0);
    check("rst_d_addr", {16'h0, d_addr}, 32'd0);
    check("rst_d_wdata", {16'h0, d_wdata}, 32'd0);
    check("rst_wb_ir", {16'h0, wb_ir}, 32'd0);
    check("rst_reg_c1", {16'h0, reg_c1}, 32'd0);
    check("rst_mem_err", {31'h0, mem_err}, 32'd0);
    check("rst_stall", {31'h0, stall}, 32'd0);
    #1 reset = 1'b1;
    tick();

    do_nonmem("add", AddIr, 16'h1234);
    do_nonmem("nop", 16'h0000, 16'h0F0F);

    // Not in exec and a stray ack in IDLE: everything holds.
    state   = NotExec;
    mem_ir  = LoadIr;
    reg_C   = 16'h7777;
    d_ack   = 1'b1;
    d_rdata = 16'hDEAD;
    #1 check("hold_stall", {31'h0, stall}, 32'd0);
    tick();
    d_ack = 1'b0;
    check("hold_req", {31'h0, d_req}, 32'd0);
    check("hold_wb_ir", {16'h0, wb_ir}, 32'd0);
    check("hold_reg_c1", {16'h0, reg_c1}, 32'h0F0F);

    do_mem("load", LoadIr, 16'h0040, 1'b0, 16'hA5A5, 16'hBEEF, 0, 1'b0);
    do_mem("store", StoreIr, 16'h0010, 1'b1, 16'h5A5A, 16'h1111, 3, 1'b0);
    do_mem("load_nx", LoadIr, 16'h0222, 1'b0, 16'h3C3C, 16'hCAFE, 2, 1'b1);

    // Back-to-back loads: the second issues right after the first completes.
    do_mem("b2b_a", LoadIr, 16'h0100, 1'b0, 16'h0, 16'h1357, 0, 1'b0);
    do_mem("b2b_b", {`LOAD, 11'h7FF}, 16'h0101, 1'b0, 16'h0, 16'h2468, 0, 1'b0);
    state = NotExec;
    tick();

`ifdef MEM_TIMEOUT_EN
    state  = `EXEC;
    mem_ir = LoadIr;
    reg_C  = 16'h0300;
    dw     = 1'b0;
    sb_q.push_back(32'h0);
    #1 check("to_issue_stall", {31'h0, stall}, 32'd1);
    tick();
    for (int i = 1; i <= 15; i++) begin
      check("to_req", {31'h0, d_req}, 32'd1);
      #1 check("to_stall", {31'h0, stall}, (i < 15) ? 32'd1 : 32'd0);
      tick();
    end
    check("to_req_fall", {31'h0, d_req}, 32'd0);
    check("to_mem_err", {31'h0, mem_err}, 32'd1);
    check_wb("to");
    do_nonmem("to_add", AddIr, 16'h4321);
    check("to_err_sticky", {31'h0, mem_err}, 32'd1);
`else
    check("no_mem_err", {31'h0, mem_err}, 32'd0);
`endif

    // Reset while a LOAD is outstanding.
    state  = `EXEC;
    mem_ir = LoadIr;
    reg_C  = 16'h0500;
    dw     = 1'b0;
    tick();
    state = NotExec;
    check("mid_req", {31'h0, d_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, d_req}, 32'd0);
    check("mid_rst_wb_ir", {16'h0, wb_ir}, 32'd0);
    check("mid_rst_reg_c1", {16'h0, reg_c1}, 32'd0);
    check("mid_rst_stall", {31'h0, stall}, 32'd0);
    check("mid_rst_mem_err", {31'h0, mem_err}, 32'd0);
    #1 reset = 1'b1;
    tick();
    do_nonmem("post_rst", AddIr, 16'h00AA);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 16-bit pipelined core, directly downstream of the execute stage. Consumes the execute stage's outputs (`mem_ir`, `reg_C`, `dw`, `smdr1`), performs LOAD/STORE transactions against the data memory over a request/acknowledge handshake, and registers the instruction and result for write-back. While a transaction is outstanding it asserts `stall` so upstream stages hold their registers.

## Interface
- `TIMEOUT`, default 15: maximum number of ACCESS-state cycles waited for `d_ack`. Used only when `MEM_TIMEOUT_EN` is defined; legal range 1..15.

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `state`  in  1  CPU run state; the stage advances only when equal to `` `exec ``
- `mem_ir`  in  16  instruction from execute; opcode is `mem_ir[15:11]`
- `reg_C`  in  16  ALU result; used as the memory address for LOAD/STORE
- `dw`  in  1  store request from execute
- `smdr1`  in  16  store data from execute
- `d_ack`  in  1  data memory acknowledge, one-cycle pulse
- `d_rdata`  in  16  read data, valid in the cycle `d_ack`=1
- `d_req`  out  1  registered memory request
- `d_we`  out  1  registered write enable: 1 = store, 0 = load
- `d_addr`  out  16  registered address
- `d_wdata`  out  16  registered write data
- `wb_ir`  out  16  instruction to write-back
- `reg_C1`  out  16  result to write-back: load data or pass-through `reg_C`
- `stall`  out  1  combinational; 1 = upstream must hold
- `mem_err`  out  1  sticky timeout flag

## Operation
- Two-state FSM: IDLE, ACCESS. Memory op: `mem_ir[15:11]` == `` `LOAD `` or `dw`=1.
- Reset (async): FSM=IDLE. `d_req`, `d_we`, `d_addr`, `d_wdata`, `wb_ir`, `reg_C1`, `mem_err` all 0. `d_req` drops immediately, including during ACCESS; any outstanding transaction is abandoned.
- IDLE, `state`≠`` `exec ``: all registers hold.
- IDLE, `` `exec ``, non-memory op (including `mem_ir`=0 NOP): `wb_ir`<=`mem_ir`, `reg_C1`<=`reg_C`. Stays in IDLE.
- IDLE, `` `exec ``, memory op:
  - `d_req`<=1, `d_we`<=`dw`, `d_addr`<=`reg_C`, `d_wdata`<=`dw` ? `smdr1` : 0.
  - `wb_ir` and `reg_C1` hold. Next state ACCESS.
- ACCESS proceeds regardless of `state`, so a started transaction always finishes.
- ACCESS, `d_ack`=1:
  - `d_req`<=0, `d_we`<=0.
  - `wb_ir`<=`mem_ir`.
  - `reg_C1`<=`d_rdata` for LOAD; `reg_C` for STORE.
  - Next state IDLE.
- ACCESS, `d_ack`=0: stay in ACCESS. All outputs hold.
- `d_ack` while in IDLE is ignored.
- `stall` = (IDLE ∧ `` `exec `` ∧ memory op) ∨ (ACCESS ∧ ¬`d_ack`).
- Upstream holds `mem_ir`, `reg_C`, `dw`, `smdr1` stable while `stall`=1.
- Arithmetic: no computation; all paths are 16-bit copies with no width change.

## Timing
- Non-memory instruction: 1-cycle latency, `stall` never asserted.
- Memory instruction:
  - Cycle 0: issue cycle (IDLE); `stall`=1.
  - Cycle 1: `d_req`=1.
  - The cycle `d_ack` arrives: `stall`=0.
  - Next edge: `wb_ir` and `reg_C1` update.
  - Minimum latency 2 cycles, when `d_ack` comes in the first ACCESS cycle.
- Back-to-back memory ops: the second issues in the cycle after completion. The IDLE cycle is mandatory; `d_req` deasserts for at least 1 cycle between transactions.
- The memory samples `d_addr`, `d_we`, `d_wdata` while `d_req`=1. These are stable for the whole ACCESS period.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A 4-bit counter clears on entering ACCESS and increments each ACCESS cycle without `d_ack`.
  - When it reaches `TIMEOUT`: `d_req`<=0, `d_we`<=0, `mem_err`<=1 (sticky until reset), `wb_ir`<=0 (bubble), `reg_C1`<=0, FSM→IDLE.
  - `stall` is 0 in the terminating cycle.
  - `d_ack` and timeout in the same cycle: `d_ack` wins.
- `MEM_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely; `mem_err` tied 0; `TIMEOUT` unused.

## Test plan
- Reset, then `` `exec `` with ADD IR, `reg_C`=0x1234 -> next edge `wb_ir`=ADD IR, `reg_C1`=0x1234, `stall` never 1, `d_req`=0.
- LOAD, `reg_C`=0x0040, `d_ack` in the 1st ACCESS cycle with `d_rdata`=0xBEEF -> `d_req`=1 for 1 cycle, `d_addr`=0x0040, `d_we`=0, `stall` high 1 cycle, `reg_C1`=0xBEEF.
- STORE, `dw`=1, `reg_C`=0x0010, `smdr1`=0x5A5A, `d_ack` after 3 cycles -> `d_we`=1, `d_wdata`=0x5A5A held 3 cycles, `reg_C1`=0x0010, `wb_ir`=STORE IR.
- LOAD in ACCESS, drop `state` out of `` `exec `` and then ack -> completes normally. Reset asserted mid-ACCESS -> `d_req`, `wb_ir`, `reg_C1` = 0 immediately.
- `MEM_TIMEOUT_EN`, `TIMEOUT`=15, no ack -> `d_req` falls after 15 ACCESS cycles, `mem_err`=1, `wb_ir`=0. A following ADD completes normally, `mem_err` stays 1.
- Two consecutive LOADs with immediate acks -> `d_req` pattern 1,0,1, total 4 cycles, both results delivered in order.
